multicycle_cpu_core: RTL and testbench

//  Parametrised multi-cycle successor to the single-cycle computer core. Executes the existing 16-bit, 16-opcode ISA.
//  FSM-sequenced: FETCH/EXEC/MEM/WB. Data memory sits behind a req/ready handshake, so it may stall. Adds resumable halt,

---
 rtl/cpu_isa_pkg.sv | 58 +++++
 rtl/core_call_stack.sv | 50 +++++
 rtl/multicycle_cpu_core.sv | 234 +++++++++++++++++++++++
 tb/tb_multicycle_cpu_core.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_isa_pkg.sv
// Shared ISA definitions for the multi-cycle core: opcodes, ALU operation
// codes, sequencer state encoding and branch-condition bit positions.
package cpu_isa_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_HLT = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_NOR = 4'h4;
  localparam logic [3:0] OP_AND = 4'h5;
  localparam logic [3:0] OP_XOR = 4'h6;
  localparam logic [3:0] OP_RSH = 4'h7;
  localparam logic [3:0] OP_LDI = 4'h8;
  localparam logic [3:0] OP_ADI = 4'h9;
  localparam logic [3:0] OP_JMP = 4'hA;
  localparam logic [3:0] OP_BRH = 4'hB;
  localparam logic [3:0] OP_CAL = 4'hC;
  localparam logic [3:0] OP_RET = 4'hD;
  localparam logic [3:0] OP_LOD = 4'hE;
  localparam logic [3:0] OP_STR = 4'hF;

  // BRH: ir[11] selects carry (1) or zero (0); ir[10] is the value that takes the branch.
  localparam int BRH_SEL_BIT = 11;
  localparam int BRH_VAL_BIT = 10;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_NOR,
    ALU_AND,
    ALU_XOR,
    ALU_RSH,
    ALU_PASS
  } alu_op_t;

  typedef enum logic [2:0] {
    S_FETCH,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT,
    S_FAULT
  } state_t;

  // Map an opcode onto the ALU operation it needs; ADI and non-ALU opcodes use ADD.
  function automatic alu_op_t alu_op_of(input logic [3:0] op);
    case (op)
      OP_SUB:  return ALU_SUB;
      OP_NOR:  return ALU_NOR;
      OP_AND:  return ALU_AND;
      OP_XOR:  return ALU_XOR;
      OP_RSH:  return ALU_RSH;
      OP_LDI:  return ALU_PASS;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/core_call_stack.sv
// Return-address stack for CAL/RET. Holds only the stack pointer and the
// entries; push on full and pop on empty are ignored so contents stay intact.
module core_call_stack #(
  parameter int WIDTH     = 10,
  parameter int PTR_WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic             full,
  output logic             empty
);

  localparam int DEPTH = 2 ** PTR_WIDTH;
  // sp is one bit wider than the index so that "full" is distinguishable from "empty".
  localparam logic [PTR_WIDTH:0] FULL_COUNT = (PTR_WIDTH + 1)'(DEPTH);

  logic [PTR_WIDTH:0]   sp;
  logic [WIDTH-1:0]     entries [DEPTH];
  logic [PTR_WIDTH-1:0] wr_idx;
  logic [PTR_WIDTH-1:0] top_idx;

  assign full    = (sp == FULL_COUNT);
  assign empty   = (sp == '0);
  assign wr_idx  = sp[PTR_WIDTH-1:0];
  assign top_idx = wr_idx - PTR_WIDTH'(1);
  assign top     = entries[top_idx];

  // Stack pointer: count pushes and pops, refusing overflow and underflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp <= '0;
    end else if (push && !full) begin
      sp <= sp + (PTR_WIDTH + 1)'(1);
    end else if (pop && !empty) begin
      sp <= sp - (PTR_WIDTH + 1)'(1);
    end
  end

  // Entry storage: write the return address at the current free slot.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      entries[wr_idx] <= push_data;
    end
  end

endmodule

// File: rtl/multicycle_cpu_core.sv
// Multi-cycle core for the 16-bit ISA. FETCH/EXEC/MEM/WB sequencing, a
// stallable req/ready data port, resumable halt, persistent flags, R0 tied
// to zero and a sticky fault on call-stack overflow/underflow.
module multicycle_cpu_core #(
  parameter int WORD_SIZE       = 64,
  parameter int DATA_ADDR_SIZE  = 8,
  parameter int IADDR_SIZE      = 10,
  parameter int REG_ADDR_SIZE   = 4,
  parameter int STACK_PTR_WIDTH = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      run,
  output logic [IADDR_SIZE-1:0]     imem_addr,
  input  logic [15:0]               imem_data,
  output logic                      dmem_req,
  output logic                      dmem_we,
  output logic [DATA_ADDR_SIZE-1:0] dmem_addr,
  output logic [WORD_SIZE-1:0]      dmem_wdata,
  input  logic [WORD_SIZE-1:0]      dmem_rdata,
  input  logic                      dmem_ready,
  output logic                      halted,
  output logic                      fault,
  output logic [IADDR_SIZE-1:0]     pc_out
);

  import cpu_isa_pkg::*;

  localparam int NUM_REGS = 2 ** REG_ADDR_SIZE;

  state_t                     state, state_next;
  logic [IADDR_SIZE-1:0]      pc, pc_inc, pc_target, pc_next, stack_top;
  logic [15:0]                ir;
  logic [WORD_SIZE-1:0]       regs [NUM_REGS];
  logic [WORD_SIZE-1:0]       ra_val, rb_val, imm_ext, alu_b, alu_res, load_data;
  logic [WORD_SIZE-1:0]       reg_wdata;
  logic [REG_ADDR_SIZE-1:0]   ra_idx, rb_idx, rd_idx, reg_waddr;
  logic [3:0]                 op;
  logic                       zf, cf, alu_cf, brh_cond, brh_taken;
  logic                       stack_full, stack_empty;
  logic                       ir_load, pc_we, reg_we, flag_we, push, pop, mem_start, mem_accept;

  // Instruction field decode and register reads; R0 always reads as zero.
  assign op        = ir[15:12];
  assign ra_idx    = REG_ADDR_SIZE'(ir[11:8]);
  assign rb_idx    = REG_ADDR_SIZE'(ir[7:4]);
  assign rd_idx    = REG_ADDR_SIZE'(ir[3:0]);
  assign ra_val    = (ra_idx == '0) ? '0 : regs[ra_idx];
  assign rb_val    = (rb_idx == '0) ? '0 : regs[rb_idx];
  assign imm_ext   = WORD_SIZE'(ir[7:0]);
  assign pc_inc    = pc + IADDR_SIZE'(1);
  assign pc_target = IADDR_SIZE'(ir[9:0]);
  assign brh_cond  = ir[BRH_SEL_BIT] ? cf : zf;
  assign brh_taken = (brh_cond == ir[BRH_VAL_BIT]);
  assign alu_b     = (op == OP_LDI || op == OP_ADI) ? imm_ext : rb_val;
  assign imem_addr = pc;
  assign pc_out    = pc;

  // ALU: result and carry/borrow; logic ops and shifts clear the carry.
  always_comb begin
    alu_res = '0;
    alu_cf  = 1'b0;
    case (alu_op_of(op))
      ALU_ADD:  {alu_cf, alu_res} = {1'b0, ra_val} + {1'b0, alu_b};
      ALU_SUB:  begin
        alu_res = ra_val - alu_b;
        alu_cf  = (ra_val < alu_b);
      end
      ALU_NOR:  alu_res = ~(ra_val | alu_b);
      ALU_AND:  alu_res = ra_val & alu_b;
      ALU_XOR:  alu_res = ra_val ^ alu_b;
      ALU_RSH:  alu_res = ra_val >> alu_b[5:0];
      ALU_PASS: alu_res = alu_b;
      default:  alu_res = '0;
    endcase
  end

  core_call_stack #(
    .WIDTH    (IADDR_SIZE),
    .PTR_WIDTH(STACK_PTR_WIDTH)
  ) u_stack (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pop      (pop),
    .push_data(pc_inc),
    .top      (stack_top),
    .full     (stack_full),
    .empty    (stack_empty)
  );

  // Sequencer state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_FETCH;
    else     state <= state_next;
  end

  // Sequencer next-state: memory ops detour through MEM (and WB for loads).
  always_comb begin
    state_next = state;
    case (state)
      S_FETCH: state_next = S_EXEC;
      S_EXEC: begin
        case (op)
          OP_HLT:         state_next = S_HALT;
          OP_CAL:         state_next = stack_full ? S_FAULT : S_FETCH;
          OP_RET:         state_next = stack_empty ? S_FAULT : S_FETCH;
          OP_LOD, OP_STR: state_next = S_MEM;
          default:        state_next = S_FETCH;
        endcase
      end
      S_MEM:   if (dmem_ready) state_next = (op == OP_STR) ? S_FETCH : S_WB;
      S_WB:    state_next = S_FETCH;
      S_HALT:  if (run) state_next = S_FETCH;
      S_FAULT: state_next = S_FAULT;
      default: state_next = S_FETCH;
    endcase
  end

  // Sequencer outputs: status flags and the per-state datapath strobes.
  always_comb begin
    halted     = (state == S_HALT) || (state == S_FAULT);
    fault      = (state == S_FAULT);
    ir_load    = 1'b0;
    pc_we      = 1'b0;
    pc_next    = pc_inc;
    reg_we     = 1'b0;
    reg_waddr  = '0;
    reg_wdata  = '0;
    flag_we    = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;
    mem_start  = 1'b0;
    mem_accept = 1'b0;
    case (state)
      S_FETCH: ir_load = 1'b1;
      S_EXEC: begin
        case (op)
          OP_NOP, OP_HLT: pc_we = 1'b1;
          OP_ADD, OP_SUB, OP_NOR, OP_AND, OP_XOR, OP_RSH: begin
            pc_we     = 1'b1;
            reg_we    = 1'b1;
            reg_waddr = rd_idx;
            reg_wdata = alu_res;
            flag_we   = 1'b1;
          end
          OP_LDI, OP_ADI: begin
            pc_we     = 1'b1;
            reg_we    = 1'b1;
            reg_waddr = ra_idx;
            reg_wdata = alu_res;
            flag_we   = (op == OP_ADI);
          end
          OP_JMP: begin
            pc_we   = 1'b1;
            pc_next = pc_target;
          end
          OP_BRH: begin
            pc_we   = 1'b1;
            pc_next = brh_taken ? pc_target : pc_inc;
          end
          OP_CAL: begin
            pc_we   = !stack_full;
            push    = !stack_full;
            pc_next = pc_target;
          end
          OP_RET: begin
            pc_we   = !stack_empty;
            pop     = !stack_empty;
            pc_next = stack_top;
          end
          default: mem_start = 1'b1;
        endcase
      end
      S_MEM: begin
        mem_accept = dmem_ready;
        pc_we      = dmem_ready && (op == OP_STR);
      end
      S_WB: begin
        pc_we     = 1'b1;
        reg_we    = 1'b1;
        reg_waddr = rb_idx;
        reg_wdata = load_data;
      end
      default: ;
    endcase
  end

  // Architectural control state: instruction register, PC and flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir <= '0;
      pc <= '0;
      zf <= 1'b0;
      cf <= 1'b0;
    end else begin
      if (ir_load) ir <= imem_data;
      if (pc_we)   pc <= pc_next;
      if (flag_we) begin
        zf <= (alu_res == '0);
        cf <= alu_cf;
      end
    end
  end

  // Register file; writes to R0 are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (reg_we && reg_waddr != '0) begin
      regs[reg_waddr] <= reg_wdata;
    end
  end

  // Data port: launch in EXEC, hold stable through MEM, drop on accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      load_data  <= '0;
    end else if (mem_start) begin
      dmem_req   <= 1'b1;
      dmem_we    <= (op == OP_STR);
      dmem_addr  <= ra_val[DATA_ADDR_SIZE-1:0] + DATA_ADDR_SIZE'(ir[3:0]);
      dmem_wdata <= rb_val;
    end else if (mem_accept) begin
      dmem_req  <= 1'b0;
      load_data <= dmem_rdata;
    end
  end

endmodule

// File: tb/tb_multicycle_cpu_core.sv
// Directed bench for multicycle_cpu_core: programs are loaded into a bench
// instruction memory, a data memory model answers with a configurable number
// of wait cycles, and each scenario task checks its own hand-computed results.
module tb_multicycle_cpu_core;

  localparam int WS  = 64;
  localparam int DA  = 8;
  localparam int IA  = 10;
  localparam int RA  = 4;
  localparam int SPW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          run;
  logic [IA-1:0] imem_addr;
  logic [15:0]   imem_data;
  logic          dmem_req;
  logic          dmem_we;
  logic [DA-1:0] dmem_addr;
  logic [WS-1:0] dmem_wdata;
  logic [WS-1:0] dmem_rdata;
  logic          dmem_ready;
  logic          halted;
  logic          fault;
  logic [IA-1:0] pc_out;

  logic [15:0]   imem [0:1023];
  logic [WS-1:0] dmem [0:255];

  int errors = 0;
  int checks = 0;
  int ready_delay = 0;
  int wait_cnt = 0;
  int req_cycles = 0;
  int last_req_cycles = 0;
  logic          req_stable, last_req_stable;
  logic [DA-1:0] first_addr, last_store_addr;
  logic          first_we;
  logic [WS-1:0] first_wdata, last_store_data;

  multicycle_cpu_core #(
    .WORD_SIZE      (WS),
    .DATA_ADDR_SIZE (DA),
    .IADDR_SIZE     (IA),
    .REG_ADDR_SIZE  (RA),
    .STACK_PTR_WIDTH(SPW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .imem_addr (imem_addr),
    .imem_data (imem_data),
    .dmem_req  (dmem_req),
    .dmem_we   (dmem_we),
    .dmem_addr (dmem_addr),
    .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata),
    .dmem_ready(dmem_ready),
    .halted    (halted),
    .fault     (fault),
    .pc_out    (pc_out)
  );

  always #5 clk = ~clk;

  assign imem_data  = imem[imem_addr];
  assign dmem_rdata = dmem[dmem_addr];

  // Data memory responder: inserts ready_delay wait cycles and tracks request stability.
  always @(negedge clk) begin
    if (dmem_req) begin
      if (req_cycles == 0) begin
        first_addr  = dmem_addr;
        first_we    = dmem_we;
        first_wdata = dmem_wdata;
        req_stable  = 1'b1;
      end else if (dmem_addr !== first_addr || dmem_we !== first_we || dmem_wdata !== first_wdata) begin
        req_stable = 1'b0;
      end
      req_cycles = req_cycles + 1;
      if (wait_cnt < ready_delay) begin
        dmem_ready = 1'b0;
        wait_cnt   = wait_cnt + 1;
      end else begin
        dmem_ready = 1'b1;
      end
    end else begin
      dmem_ready = 1'b0;
      wait_cnt   = 0;
      req_cycles = 0;
    end
  end

  // Completed transfers: commit stores and log one line per transaction.
  always @(posedge clk) begin
    if (!rst && dmem_req && dmem_ready) begin
      if (dmem_we) begin
        dmem[dmem_addr] <= dmem_wdata;
        last_store_addr <= dmem_addr;
        last_store_data <= dmem_wdata;
      end
      last_req_cycles <= req_cycles;
      last_req_stable <= req_stable;
      $display("[%0t] dmem %s addr=%0h data=%0h req_cycles=%0d", $time, dmem_we ? "ST" : "LD",
               dmem_addr, dmem_we ? dmem_wdata : dmem_rdata, req_cycles);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_imem();
    for (int i = 0; i < 1024; i++) imem[i] = 16'h0000;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    run = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic run_until_halt(input int max_cycles, output int cyc);
    cyc = 0;
    while (!halted && cyc < max_cycles) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic pulse_run();
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
  endtask

  // LDI/LDI/ADD/HLT timing, then resume past HLT and check r3 and zf=0.
  task automatic test_add_halt_resume();
    int cyc;
    clear_imem();
    imem[0] = 16'h8105; imem[1] = 16'h8203; imem[2] = 16'h2123; imem[3] = 16'h1000;
    imem[4] = 16'hB420; imem[5] = 16'hF030; imem[6] = 16'h1000; imem[32] = 16'h1000;
    ready_delay = 0;
    do_reset();
    run_until_halt(7, cyc);
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL t1_early_halt: got %b want 0 at cycle 7", halted); end
    run_until_halt(20, cyc);
    checks++; if (cyc !== 1) begin errors++; $display("FAIL t1_halt_cycle: got %0d extra cycles want 1 (halt at 8)", cyc); end
    checks++; if (pc_out !== 10'd4) begin errors++; $display("FAIL t1_halt_pc: got %0h want 4", pc_out); end
    pulse_run();
    checks++; if (halted !== 1'b0 || pc_out !== 10'd4) begin errors++; $display("FAIL t1_resume: halted=%b pc=%0h want 0/4", halted, pc_out); end
    run_until_halt(40, cyc);
    checks++; if (cyc !== 7) begin errors++; $display("FAIL t1_resume_cycles: got %0d want 7", cyc); end
    checks++; if (pc_out !== 10'd7) begin errors++; $display("FAIL t1_zf_clear_branch: pc got %0h want 7", pc_out); end
    checks++; if (dmem[0] !== 64'd8) begin errors++; $display("FAIL t1_r3_sum: got %0h want 8", dmem[0]); end
  endtask

  // SUB to zero, BRH zero taken, ADD into R0 discarded.
  task automatic test_branch_r0();
    int cyc;
    clear_imem();
    imem[0] = 16'h8101; imem[1] = 16'h3112; imem[2] = 16'hB406; imem[3] = 16'h1000;
    imem[6] = 16'h0000; imem[7] = 16'h2110; imem[8] = 16'hF005; imem[9] = 16'h1000;
    ready_delay = 0;
    do_reset();
    run_cycles(6);
    checks++; if (pc_out !== 10'd6) begin errors++; $display("FAIL t2_branch_taken: pc got %0h want 6", pc_out); end
    run_until_halt(40, cyc);
    checks++; if (cyc !== 9) begin errors++; $display("FAIL t2_cycles: got %0d want 9", cyc); end
    checks++; if (pc_out !== 10'd10) begin errors++; $display("FAIL t2_halt_pc: got %0h want a", pc_out); end
    checks++; if (last_store_addr !== 8'd5 || last_store_data !== 64'd0) begin errors++; $display("FAIL t2_r0_zero: addr=%0h data=%0h want 5/0", last_store_addr, last_store_data); end
  endtask

  // Store then load through a 3-wait-cycle memory.
  task automatic test_mem_stall();
    int cyc;
    clear_imem();
    imem[0] = 16'h81AB; imem[1] = 16'hF012; imem[2] = 16'hE042; imem[3] = 16'hF043; imem[4] = 16'h1000;
    ready_delay = 3;
    do_reset();
    run_cycles(12);
    checks++; if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || dmem_addr !== 8'd2) begin errors++; $display("FAIL t3_load_req: req=%b we=%b addr=%0h want 1/0/2", dmem_req, dmem_we, dmem_addr); end
    run_cycles(2);
    checks++; if (last_req_cycles !== 4) begin errors++; $display("FAIL t3_req_cycles: got %0d want 4", last_req_cycles); end
    checks++; if (last_req_stable !== 1'b1) begin errors++; $display("FAIL t3_req_stable: got %b want 1", last_req_stable); end
    checks++; if (dmem[2] !== 64'hAB) begin errors++; $display("FAIL t3_store: got %0h want ab", dmem[2]); end
    run_until_halt(40, cyc);
    checks++; if (cyc !== 9) begin errors++; $display("FAIL t3_cycles: got %0d want 9", cyc); end
    checks++; if (dmem[3] !== 64'hAB) begin errors++; $display("FAIL t3_load_value: got %0h want ab", dmem[3]); end
    ready_delay = 0;
  endtask

  // Asynchronous reset clears outputs immediately; core restarts at pc 0.
  task automatic test_reset();
    rst = 1'b1;
    #1;
    checks++; if (pc_out !== 10'd0 || halted !== 1'b0 || fault !== 1'b0) begin errors++; $display("FAIL rst_state: pc=%0h halted=%b fault=%b want 0/0/0", pc_out, halted, fault); end
    checks++; if (dmem_req !== 1'b0 || dmem_we !== 1'b0 || dmem_addr !== 8'd0 || dmem_wdata !== 64'd0) begin errors++; $display("FAIL rst_dmem: req=%b we=%b addr=%0h wdata=%0h want zeros", dmem_req, dmem_we, dmem_addr, dmem_wdata); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  // AND/XOR/RSH/ADI/NOR result values.
  task automatic test_alu_ops();
    int cyc;
    clear_imem();
    imem[0]  = 16'h81F0; imem[1]  = 16'h823C; imem[2]  = 16'h5123; imem[3]  = 16'h6124;
    imem[4]  = 16'h8604; imem[5]  = 16'h7167; imem[6]  = 16'h9110; imem[7]  = 16'hF030;
    imem[8]  = 16'hF041; imem[9]  = 16'hF072; imem[10] = 16'hF013; imem[11] = 16'h4008;
    imem[12] = 16'hF084; imem[13] = 16'h1000;
    do_reset();
    run_until_halt(80, cyc);
    checks++; if (cyc !== 33) begin errors++; $display("FAIL alu_cycles: got %0d want 33", cyc); end
    checks++; if (dmem[0] !== 64'h30) begin errors++; $display("FAIL alu_and: got %0h want 30", dmem[0]); end
    checks++; if (dmem[1] !== 64'hCC) begin errors++; $display("FAIL alu_xor: got %0h want cc", dmem[1]); end
    checks++; if (dmem[2] !== 64'h0F) begin errors++; $display("FAIL alu_rsh: got %0h want f", dmem[2]); end
    checks++; if (dmem[3] !== 64'h100) begin errors++; $display("FAIL alu_adi: got %0h want 100", dmem[3]); end
    checks++; if (dmem[4] !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL alu_nor: got %0h want all ones", dmem[4]); end
  endtask

  // Wrapping ADD sets zf/cf, LDI holds them, ADI clears them, SUB borrow sets cf.
  task automatic test_flags();
    int cyc;
    clear_imem();
    imem[0]  = 16'h8101; imem[1]  = 16'h4002; imem[2]  = 16'h2213; imem[3]  = 16'h8507;
    imem[4]  = 16'hB40A; imem[5]  = 16'h1000; imem[10] = 16'hBC10; imem[11] = 16'h1000;
    imem[16] = 16'h9500; imem[17] = 16'hB820; imem[18] = 16'h1000;
    imem[32] = 16'hF050; imem[33] = 16'hF031; imem[34] = 16'h3152; imem[35] = 16'hBC30;
    imem[36] = 16'h1000; imem[48] = 16'hF022; imem[49] = 16'h1000;
    do_reset();
    run_until_halt(80, cyc);
    checks++; if (cyc !== 31) begin errors++; $display("FAIL flag_cycles: got %0d want 31", cyc); end
    checks++; if (pc_out !== 10'h32) begin errors++; $display("FAIL flag_path_pc: got %0h want 32", pc_out); end
    checks++; if (dmem[0] !== 64'd7 || dmem[1] !== 64'd0) begin errors++; $display("FAIL flag_regs: r5=%0h r3=%0h want 7/0", dmem[0], dmem[1]); end
    checks++; if (dmem[2] !== 64'hFFFF_FFFF_FFFF_FFFA) begin errors++; $display("FAIL flag_sub_borrow: got %0h want fffffffffffffffa", dmem[2]); end
  endtask

  // CAL/RET round trip, overflow on the 65th nested CAL, underflow on RET.
  task automatic test_call_stack();
    int cyc;
    clear_imem();
    imem[0] = 16'hC010; imem[1] = 16'h1000; imem[16] = 16'hD000;
    do_reset();
    run_cycles(2);
    checks++; if (pc_out !== 10'h10) begin errors++; $display("FAIL cal_target: pc got %0h want 10", pc_out); end
    run_until_halt(20, cyc);
    checks++; if (cyc !== 4 || pc_out !== 10'd2) begin errors++; $display("FAIL ret_return: cyc=%0d pc=%0h want 4/2", cyc, pc_out); end
    checks++; if (dut.u_stack.sp !== 7'd0) begin errors++; $display("FAIL ret_sp: got %0d want 0", dut.u_stack.sp); end
    clear_imem();
    imem[0] = 16'hA020; imem[32] = 16'hC020;
    do_reset();
    run_cycles(131);
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL ovf_early: fault got %b want 0 at cycle 131", fault); end
    run_cycles(1);
    checks++; if (fault !== 1'b1 || halted !== 1'b1) begin errors++; $display("FAIL ovf_fault: fault=%b halted=%b want 1/1", fault, halted); end
    checks++; if (dut.u_stack.sp !== 7'd64) begin errors++; $display("FAIL ovf_sp: got %0d want 64", dut.u_stack.sp); end
    run = 1'b1;
    run_cycles(3);
    run = 1'b0;
    checks++; if (fault !== 1'b1 || pc_out !== 10'h20) begin errors++; $display("FAIL ovf_sticky: fault=%b pc=%0h want 1/20", fault, pc_out); end
    clear_imem();
    imem[0] = 16'hD000;
    do_reset();
    run_cycles(2);
    checks++; if (fault !== 1'b1 || dut.u_stack.sp !== 7'd0) begin errors++; $display("FAIL udf_fault: fault=%b sp=%0d want 1/0", fault, dut.u_stack.sp); end
    do_reset();
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL udf_clear: fault got %b want 0 after rst", fault); end
  endtask

  // Resume after HLT, then reset while a store is stalled in MEM.
  task automatic test_resume_reset_mid_mem();
    int cyc;
    clear_imem();
    imem[0] = 16'h1000; imem[1] = 16'hF000; imem[2] = 16'h1000;
    ready_delay = 1000;
    do_reset();
    run_until_halt(10, cyc);
    checks++; if (cyc !== 2 || pc_out !== 10'd1) begin errors++; $display("FAIL t5_halt: cyc=%0d pc=%0h want 2/1", cyc, pc_out); end
    pulse_run();
    checks++; if (halted !== 1'b0 || pc_out !== 10'd1) begin errors++; $display("FAIL t5_resume: halted=%b pc=%0h want 0/1", halted, pc_out); end
    run_cycles(3);
    checks++; if (dmem_req !== 1'b1 || dmem_we !== 1'b1) begin errors++; $display("FAIL t5_stalled: req=%b we=%b want 1/1", dmem_req, dmem_we); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (dmem_req !== 1'b0 || pc_out !== 10'd0) begin errors++; $display("FAIL t5_async_rst: req=%b pc=%0h want 0/0", dmem_req, pc_out); end
    @(negedge clk);
    rst = 1'b0;
    ready_delay = 0;
  endtask

  initial begin
    rst = 1'b1;
    run = 1'b0;
    test_add_halt_resume();
    test_branch_r0();
    test_mem_stall();
    test_reset();
    test_alu_ops();
    test_flags();
    test_call_stack();
    test_resume_reset_mid_mem();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
